uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver for the echo path: recovers 8N1 serial frames from the rx line.
//   Presents each received word on a valid/ready output holding register.
//   Sits between the board rx pin and the echo/transmit logic.
//   Flags framing errors and overruns as single-cycle pulses.
// PARAMETERS
//   DATA_WIDTH    8            data bits per frame, sent LSB first
//   CLK_FREQ_HZ   125_000_000  clk frequency in Hz
//   BAUD_RATE     9600         line bit rate
//   (local) CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE, truncated (13020 at defaults).
//   (local) HALF_BIT = CLKS_PER_BIT/2.
//   Counter width is $clog2(CLKS_PER_BIT).
// PORTS
//   clk          in   1           system clock, all logic on rising edge
//   rst_n        in   1           asynchronous, active-low reset
//   rx_i         in   1           serial line, asynchronous to clk, idle high
//   data_o       out  DATA_WIDTH  received word, stable while valid_o=1
//   valid_o      out  1           data_o holds an unconsumed word
//   ready_i      in   1           consumer accepts data_o when valid_o&&ready_i
//   frame_err_o  out  1           1-cycle pulse: stop bit sampled low
//   overrun_o    out  1           1-cycle pulse: word lost, holding register full
// BEHAVIOUR
//   Reset (rst_n=0, async assert):
//   - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0.
//   - FSM=IDLE, counters=0; both synchronizer flops preset to 1 (idle line).
//   - Release is synchronous to clk.
//   rx_i passes through a 2-flop synchronizer; rx_s is the synchronized value (2-cycle delay).
//   FSM:
//   - IDLE: wait for rx_s=0; clear bit counter, load baud counter, go to START.
//   - START: after HALF_BIT clocks, sample rx_s.
//     - 0: reload CLKS_PER_BIT, go to DATA.
//     - 1: glitch; return to IDLE with no flags raised.
//   - DATA: every CLKS_PER_BIT clocks, shift rx_s into the MSB of the shift register (LSB first on line).
//     - After DATA_WIDTH samples, go to STOP.
//   - STOP: after CLKS_PER_BIT clocks, sample rx_s, then go to IDLE.
//     - 1: frame good.
//     - 0: frame_err_o=1 for one cycle; word discarded, valid_o/data_o unchanged.
//     - From IDLE the FSM waits for rx_s=1 before re-arming; a line held low is not
//       re-detected as a start bit.
//   Output register, on a good frame at the stop sample cycle (commit):
//   - valid_o=0, or valid_o=1 with ready_i=1 the same cycle: data_o<=word, valid_o<=1 next cycle.
//   - valid_o=1 and ready_i=0: word dropped, overrun_o=1 for one cycle; data_o keeps the old word.
//   Handshake:
//   - valid_o&&ready_i with no commit that cycle: valid_o<=0 next cycle; data_o retains its value.
//   - valid_o never drops without ready_i; data_o never changes while valid_o=1 && !ready_i.
//   Latency: valid_o rises 1 clk after the mid-stop-bit sample, i.e. about 9.5 bit times + 3 clks
//     after the start-bit falling edge on rx_i.
//   A break condition (rx_i held low) yields frame_err_o once, then the FSM idles until the line
//     returns high.
//   Mid-operation reset aborts the frame immediately; the next start bit after release is
//     received normally.
// TESTING (bench: CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000 -> CLKS_PER_BIT=10)
//   1. Reset: rst_n=0 with rx_i=1 -> all outputs 0; release; 200 idle clks -> valid_o stays 0.
//   2. Good frame: send 0xA5 (start, 10100101 LSB first, stop), ready_i=1
//      -> data_o=0xA5, valid_o high exactly 1 cycle, no flag pulses.
//   3. Glitch: rx_i low for 3 clks then high -> no valid_o, no flags; a following 0x3C is received
//      as 0x3C.
//   4. Framing error: send 0x5A with stop bit 0 -> frame_err_o one pulse, valid_o stays 0;
//      then line high and 0x81 received correctly.
//   5. Backpressure: ready_i=0, send 0x11 then 0x22
//      -> valid_o=1, data_o=0x11, overrun_o one pulse at the 0x22 stop sample;
//      ready_i=1 -> valid_o drops next cycle.
//   6. Reset mid-frame: assert rst_n=0 after bit 3 of 0xFF -> outputs 0 immediately, no valid;
//      after release, 0x00 is received as 0x00.

Source files
------------

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver with a valid/ready output holding register
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  armed_q, armed_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  commit;

  // Synchronizer presets to the idle-high level so reset never fakes a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    armed_d = armed_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // After a stop sample the line must be seen high before a new start counts.
        if (!armed_q) begin
          if (rx_s_q) armed_d = 1'b1;
        end else if (!rx_s_q) begin
          bit_d   = '0;
          cnt_d   = CNT_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            cnt_d   = CNT_FULL;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == BIT_LAST) state_d = S_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          armed_d = 1'b0;
          if (rx_s_q) commit = 1'b1;
          else        ferr_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx (10 clks per bit)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  int         vcnt = 0;
  int         fcnt = 0;
  int         ocnt = 0;
  logic [7:0] last_acc = 8'h00;

  uart_rx #(
    .DATA_WIDTH (8),
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) vcnt <= vcnt + 1;
      if (valid_o && ready_i) last_acc <= data_o;
      if (frame_err_o) fcnt <= fcnt + 1;
      if (overrun_o) ocnt <= ocnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    idle(15);
  endtask

  int v0, f0, o0;

  task automatic snap();
    v0 = vcnt;
    f0 = fcnt;
    o0 = ocnt;
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b1;

    // 1. reset state, then a long idle line
    repeat (3) @(negedge clk);
    check_eq("rst_data",  32'(data_o),      32'h00);
    check_eq("rst_valid", 32'(valid_o),     32'h0);
    check_eq("rst_ferr",  32'(frame_err_o), 32'h0);
    check_eq("rst_ovr",   32'(overrun_o),   32'h0);
    rst_n = 1'b1;
    idle(200);
    check_eq("idle_valid_cnt", 32'(vcnt), 32'd0);

    // 2. good frame with consumer ready
    snap();
    send_frame(8'hA5, 1'b1);
    check_eq("a5_acc",    32'(last_acc), 32'hA5);
    check_eq("a5_data",   32'(data_o),   32'hA5);
    check_eq("a5_vcyc",   32'(vcnt - v0), 32'd1);
    check_eq("a5_flags",  32'((fcnt - f0) + (ocnt - o0)), 32'd0);

    // 3. short low glitch must be rejected, next frame still received
    snap();
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check_eq("glitch_vcyc",  32'(vcnt - v0), 32'd0);
    check_eq("glitch_flags", 32'((fcnt - f0) + (ocnt - o0)), 32'd0);
    send_frame(8'h3C, 1'b1);
    check_eq("3c_acc",  32'(last_acc), 32'h3C);
    check_eq("3c_vcyc", 32'(vcnt - v0), 32'd1);

    // 4. framing error, then recovery
    snap();
    send_frame(8'h5A, 1'b0);
    check_eq("ferr_cnt",  32'(fcnt - f0), 32'd1);
    check_eq("ferr_vcyc", 32'(vcnt - v0), 32'd0);
    check_eq("ferr_data", 32'(data_o),    32'h3C);
    idle(20);
    send_frame(8'h81, 1'b1);
    check_eq("81_acc",  32'(last_acc), 32'h81);
    check_eq("81_vcyc", 32'(vcnt - v0), 32'd1);
    check_eq("81_ferr", 32'(fcnt - f0), 32'd1);

    // 5. backpressure: second word overruns, first word held
    ready_i = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    check_eq("bp_valid1", 32'(valid_o), 32'h1);
    check_eq("bp_data1",  32'(data_o),  32'h11);
    send_frame(8'h22, 1'b1);
    check_eq("bp_valid2", 32'(valid_o),   32'h1);
    check_eq("bp_data2",  32'(data_o),    32'h11);
    check_eq("bp_ovr",    32'(ocnt - o0), 32'd1);
    check_eq("bp_ferr",   32'(fcnt - f0), 32'd0);
    #2 ready_i = 1'b1;
    check_eq("bp_hold",   32'(valid_o), 32'h1);
    @(negedge clk);
    check_eq("bp_drop",   32'(valid_o), 32'h0);
    check_eq("bp_keep",   32'(data_o),  32'h11);

    // 6. reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    rx_i  = 1'b1;
    #1;
    check_eq("mid_rst_data",  32'(data_o),                  32'h00);
    check_eq("mid_rst_flags", 32'({valid_o, frame_err_o, overrun_o}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    snap();
    check_eq("mid_rst_novalid", 32'(valid_o), 32'h0);
    send_frame(8'h00, 1'b1);
    check_eq("00_vcyc",  32'(vcnt - v0), 32'd1);
    check_eq("00_acc",   32'(last_acc),  32'h00);
    check_eq("00_flags", 32'((fcnt - f0) + (ocnt - o0)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
